// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with enable, synchronous clear, validated parallel load,
// wrap/saturate limit handling and registered limit/load-error pulses.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 3,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  limit_hit,
  output logic                  load_error
);

  localparam int unsigned         W         = 4 * DIGITS;
  localparam logic [W-1:0]        ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] count_q, count_d;
  logic         limit_q, limit_d;
  logic         lerr_q,  lerr_d;

  logic [W-1:0] inc_v, dec_v;
  logic         carry, borrow, ld_ok, at_max, at_min;

  // Full ripple of carry/borrow across all digits within one cycle.
  always_comb begin
    inc_v  = count_q;
    dec_v  = count_q;
    carry  = 1'b1;
    borrow = 1'b1;
    ld_ok  = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_v[4*k +: 4] = 4'd0;
        end else begin
          inc_v[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_v[4*k +: 4] = 4'd9;
        end else begin
          dec_v[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
      if (load_value[4*k +: 4] > 4'd9) begin
        ld_ok = 1'b0;
      end
    end
    at_max = (count_q == ALL_NINES);
    at_min = (count_q == '0);
  end

  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    lerr_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (ld_ok) begin
        count_d = load_value;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          limit_d = 1'b1;
          count_d = WRAP ? '0 : count_q;
        end else begin
          count_d = inc_v;
        end
      end else begin
        if (at_min) begin
          limit_d = 1'b1;
          count_d = WRAP ? ALL_NINES : count_q;
        end else begin
          count_d = dec_v;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      limit_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count      = count_q;
  assign limit_hit  = limit_q;
  assign load_error = lerr_q;

endmodule
